// File: rtl/fetch_unit.sv
// IF stage: owns PC, fetches over imem req/valid, feeds IF/ID.
// Ports: clk, reset, StallF, PCSrcD, PCBranchD, imem_*, PC_F,
// PC_Plus4_F, Instr_F, FetchValid_F, FetchBusy_F.
// Build option: FETCH_BUF_EN adds a 1-entry hold buffer (HOLD state).
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        PCSrcD,
  input  logic [31:0] PCBranchD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_F,
  output logic [31:0] PC_Plus4_F,
  output logic [31:0] Instr_F,
  output logic        FetchValid_F,
  output logic        FetchBusy_F
);

`ifdef FETCH_BUF_EN
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1
  } state_t;
`endif

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pend;
  logic        hold;
`ifdef FETCH_BUF_EN
  logic [31:0] buf_q;
`endif

  assign pc_plus4 = pc + 32'd4;

  // A request is open in every FETCH cycle (req is high) and in DRAIN.
  assign pend = (state == FETCH) || (state == DRAIN);

`ifdef FETCH_BUF_EN
  assign hold = (state == HOLD);
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      // An unanswered request still gets a reply; swallow it in DRAIN.
      state <= (pend && !imem_valid) ? DRAIN : FETCH;
    end else if (PCSrcD) begin
      pc    <= PCBranchD & ~32'd3;
      state <= (pend && !imem_valid) ? DRAIN : FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (imem_valid) begin
            if (!StallF) begin
              pc <= pc_plus4;
            end
`ifdef FETCH_BUF_EN
            else begin
              buf_q <= imem_rdata;
              state <= HOLD;
            end
`endif
          end
        end
        DRAIN: begin
          if (imem_valid) state <= FETCH;
        end
`ifdef FETCH_BUF_EN
        HOLD: begin
          if (!StallF) begin
            pc    <= pc_plus4;
            state <= FETCH;
          end
        end
`endif
        default: state <= FETCH;
      endcase
    end
  end

  assign imem_req   = (state == FETCH);
  assign imem_addr  = pc;
  assign PC_F       = pc;
  assign PC_Plus4_F = pc_plus4;

  assign FetchValid_F = !reset &&
    (((state == FETCH) && imem_valid) || hold);

  assign FetchBusy_F = !reset && pend && !imem_valid;

`ifdef FETCH_BUF_EN
  assign Instr_F = !FetchValid_F ? NOP_INSTR :
                   hold ? buf_q : imem_rdata;
`else
  assign Instr_F = FetchValid_F ? imem_rdata : NOP_INSTR;
`endif

endmodule
